multi_controller_manager: RTL
=============================

# multi_controller_manager

Multi-player successor to the single-player controller manager. It debounces and synchronises each player's GPIO buttons, samples the analog stick nibbles on a configurable ADC clock, and packs one 32-bit MMIO input word per player. It also runs a programmable per-player rumble/LED pattern engine driven by an MMIO command word. It sits between the board GPIO headers and the processor's MMIO input/output registers.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of controllers (1..4)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button change is accepted (>=1)
- RUMBLE_UNIT, 2000000, fastClock cycles per on/off time unit (>=1)
- CLK_DIV, 16, slowClock half-period in fastClock cycles (>=1)

Ports:
- fastClock  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- halfgpio  in  16*NUM_PLAYERS  player p occupies [16p+15:16p]: [3:0] a/b/grab/shield, [7:4] x, [11:8] D-pad, [15:12] y.
- halfoverflowgpio  in  2*NUM_PLAYERS  player p occupies [2p+1:2p]: reset, jump.
- mmioCmd  in  32  rumble command: [7:0] player index, [11:8] pulse count, [19:12] on-time units, [27:20] off-time units, [31:28] ignored.
- mmioCmdValid  in  1  one-cycle strobe qualifying mmioCmd.
- mmioBoardInput  out  32*NUM_PLAYERS  packed status word per player, at [32p+31:32p].
- ledMotorOut  out  NUM_PLAYERS  rumble/LED drive per player.
- slowClock  out  1  ADC clock.
- sampleStrobe  out  1  one-cycle pulse, coincident with each slowClock rising edge.

## Operation
- Status word per player: [3:0]=0, [7:4]=x, [11:8]=0, [15:12]=y, [19:16]=debounced a/b/grab/shield, [23:20]=debounced D-pad, [25:24]=debounced reset/jump, [26]=rumble active (FSM not IDLE), [31:27]=0.
- Synchronisation: all halfgpio and halfoverflowgpio bits pass through 2 flops.
- Debounce (10 digital bits per player, independent per bit):
  - A per-bit counter clears whenever the synced raw value equals the debounced value.
  - Otherwise the counter increments.
  - When the count reaches DEBOUNCE_CYCLES, the debounced value takes the raw value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Analog: the synced x/y nibbles are latched on the edge at which slowClock rises. They are not debounced.
- Slow clock:
  - Counter runs 0..CLK_DIV-1; slowClock toggles at the terminal count.
  - Period is exactly 2*CLK_DIV cycles (the legacy off-by-one is fixed).
  - sampleStrobe is registered and high only in the first cycle slowClock is high.
- Rumble FSM per player, states IDLE, ON, OFF:
  - A command is accepted when mmioCmdValid=1 and the index is < NUM_PLAYERS. Otherwise it is dropped with no side effects.
  - An accepted command always pre-empts the current pattern.
  - Pulse count 0 forces IDLE. Otherwise the engine loads remaining=count and enters ON.
  - ON lasts max(on,1)*RUMBLE_UNIT cycles. On exit it decrements remaining, then goes to IDLE if remaining=0, otherwise to OFF.
  - OFF lasts max(off,1)*RUMBLE_UNIT cycles, then returns to ON.
  - ledMotorOut = (state==ON), registered.
  - The legacy pattern corresponds to count=3, on=1, off=1 with RUMBLE_UNIT=2000000.
  - The duration counter width is ceil(log2(255*RUMBLE_UNIT+1)).

## Timing
- Reset (asynchronous assert, synchronous release): all outputs 0, all counters 0, debounced bits 0, analog latches 0, FSMs IDLE.
- Button latency: if a raw change is stable before edge 0, the debounced value (and mmioBoardInput) updates at edge DEBOUNCE_CYCLES+2.
- Command latency: with a strobe sampled at edge 0, ledMotorOut and status bit 26 change at edge 1. The first ON phase spans exactly max(on,1)*RUMBLE_UNIT cycles of ledMotorOut=1.
- Commands to different players on consecutive cycles are both accepted. A new command in the same cycle as a phase end wins over the phase transition.
- Reset asserted mid-pattern stops the motor immediately. No command is retained.
- Pre-empting a command restarts timing from zero; no partial phase carries over.

## Test plan
(DEBOUNCE_CYCLES=4, RUMBLE_UNIT=10, CLK_DIV=4, NUM_PLAYERS=2)
- After reset release: all outputs 0; slowClock period 8 cycles; sampleStrobe high 1 cycle in 8; no drift over 1000 cycles.
- Player 1 a-button 0→1 held: mmioBoardInput[48] rises exactly 6 edges later. A 3-cycle glitch on player 0 shield: bit 19 stays 0.
- Player 0 x=4'hA applied: appears in [7:4] only after the next slowClock rise. [3:0], [11:8] and [31:27] remain 0 throughout.
- Command {idx=0, count=3, on=2, off=1}: ledMotorOut[0] = 20 high, 10 low, 20 high, 10 low, 20 high, then 0. Bit 26 falls with the last high phase.
- Command idx=1 count=2 issued during the first ON phase: player 1 restarts cleanly. A following command idx=5 is ignored. A command count=0 stops the motor on the next edge.
- Reset asserted asynchronously mid-ON (between clock edges): ledMotorOut drops without a clock edge; after release the FSM stays IDLE until a new command.

Source files
------------

// File: rtl/multi_controller_manager.sv
// multi_controller_manager: per-player GPIO synchronisation and debouncing,
// ADC-clock analog sampling, MMIO status word packing and a programmable
// per-player rumble/LED pattern engine driven by an MMIO command word.
module multi_controller_manager #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUMBLE_UNIT     = 2000000,
    parameter int CLK_DIV         = 16
) (
    input  logic                      fastClock,
    input  logic                      resetn,
    input  logic [16*NUM_PLAYERS-1:0] halfgpio,
    input  logic [2*NUM_PLAYERS-1:0]  halfoverflowgpio,
    input  logic [31:0]               mmioCmd,
    input  logic                      mmioCmdValid,
    output logic [32*NUM_PLAYERS-1:0] mmioBoardInput,
    output logic [NUM_PLAYERS-1:0]    ledMotorOut,
    output logic                      slowClock,
    output logic                      sampleStrobe
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW   = $clog2(255 * RUMBLE_UNIT + 1);
    localparam logic [DW-1:0]   UNIT_W   = DW'(RUMBLE_UNIT);
    localparam logic [DBW-1:0]  DB_LIMIT = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } rumbleState_t;

    // Last timer value of a phase: a zero unit count still lasts one unit.
    function automatic logic [DW-1:0] phaseLast(input logic [7:0] units);
        logic [DW-1:0] w_units;
        w_units = (units == 8'd0) ? DW'(1) : DW'(units);
        return w_units * UNIT_W - DW'(1);
    endfunction

    logic [16*NUM_PLAYERS-1:0] r_gpioMeta;
    logic [16*NUM_PLAYERS-1:0] r_gpioSync;
    logic [2*NUM_PLAYERS-1:0]  r_ovfMeta;
    logic [2*NUM_PLAYERS-1:0]  r_ovfSync;

    // Two-flop synchroniser on every GPIO input bit.
    always_ff @(posedge fastClock or negedge resetn) begin
        if (!resetn) begin
            r_gpioMeta <= '0;
            r_gpioSync <= '0;
            r_ovfMeta  <= '0;
            r_ovfSync  <= '0;
        end else begin
            r_gpioMeta <= halfgpio;
            r_gpioSync <= r_gpioMeta;
            r_ovfMeta  <= halfoverflowgpio;
            r_ovfSync  <= r_ovfMeta;
        end
    end

    logic [DIVW-1:0] r_divCnt;
    logic            r_slowClock;
    logic            r_sampleStrobe;
    logic            w_slowRise;

    assign w_slowRise = (r_divCnt == DIV_LAST) && !r_slowClock;

    // ADC clock divider: toggles at terminal count, strobe marks each rise.
    always_ff @(posedge fastClock or negedge resetn) begin
        if (!resetn) begin
            r_divCnt       <= '0;
            r_slowClock    <= 1'b0;
            r_sampleStrobe <= 1'b0;
        end else begin
            if (r_divCnt == DIV_LAST) begin
                r_divCnt    <= '0;
                r_slowClock <= ~r_slowClock;
            end else begin
                r_divCnt <= r_divCnt + DIVW'(1);
            end
            r_sampleStrobe <= w_slowRise;
        end
    end

    assign slowClock    = r_slowClock;
    assign sampleStrobe = r_sampleStrobe;

    logic [7:0] w_cmdIdx;
    logic [3:0] w_cmdCount;
    logic [7:0] w_cmdOn;
    logic [7:0] w_cmdOff;
    logic       w_unusedCmdBits;

    assign w_cmdIdx        = mmioCmd[7:0];
    assign w_cmdCount      = mmioCmd[11:8];
    assign w_cmdOn         = mmioCmd[19:12];
    assign w_cmdOff        = mmioCmd[27:20];
    assign w_unusedCmdBits = ^mmioCmd[31:28];

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [9:0]    w_raw;
        logic [9:0]    w_deb;
        logic [7:0]    r_analog;
        rumbleState_t  r_state;
        rumbleState_t  w_nextState;
        logic [3:0]    r_remaining;
        logic [3:0]    w_nextRemaining;
        logic [DW-1:0] r_timer;
        logic [DW-1:0] w_nextTimer;
        logic [7:0]    r_onUnits;
        logic [7:0]    w_nextOnUnits;
        logic [7:0]    r_offUnits;
        logic [7:0]    w_nextOffUnits;
        logic          r_led;
        logic          r_busy;
        logic          w_ledDrive;
        logic          w_busyDrive;
        logic          w_cmdHit;

        assign w_raw    = {r_ovfSync[2*p +: 2], r_gpioSync[16*p+8 +: 4], r_gpioSync[16*p +: 4]};
        assign w_cmdHit = mmioCmdValid && (w_cmdIdx == 8'(p));

        for (genvar b = 0; b < 10; b++) begin : g_bit
            logic [DBW-1:0] r_cnt;
            logic           r_debBit;

            // Accept a new level only after it has differed for the full debounce window.
            always_ff @(posedge fastClock or negedge resetn) begin
                if (!resetn) begin
                    r_cnt    <= '0;
                    r_debBit <= 1'b0;
                end else if (w_raw[b] == r_debBit) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LIMIT) begin
                    r_debBit <= w_raw[b];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + DBW'(1);
                end
            end

            assign w_deb[b] = r_debBit;
        end

        // Capture the stick nibbles {y, x} on each ADC clock rise.
        always_ff @(posedge fastClock or negedge resetn) begin
            if (!resetn) begin
                r_analog <= '0;
            end else if (w_slowRise) begin
                r_analog <= {r_gpioSync[16*p+12 +: 4], r_gpioSync[16*p+4 +: 4]};
            end
        end

        // Rumble state register plus registered motor and busy outputs.
        always_ff @(posedge fastClock or negedge resetn) begin
            if (!resetn) begin
                r_state     <= ST_IDLE;
                r_remaining <= '0;
                r_timer     <= '0;
                r_onUnits   <= '0;
                r_offUnits  <= '0;
                r_led       <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                r_state     <= w_nextState;
                r_remaining <= w_nextRemaining;
                r_timer     <= w_nextTimer;
                r_onUnits   <= w_nextOnUnits;
                r_offUnits  <= w_nextOffUnits;
                r_led       <= w_ledDrive;
                r_busy      <= w_busyDrive;
            end
        end

        // Next-state logic: an accepted command always overrides phase sequencing.
        always_comb begin
            w_nextState     = r_state;
            w_nextRemaining = r_remaining;
            w_nextTimer     = r_timer;
            w_nextOnUnits   = r_onUnits;
            w_nextOffUnits  = r_offUnits;
            if (w_cmdHit) begin
                w_nextOnUnits  = w_cmdOn;
                w_nextOffUnits = w_cmdOff;
                if (w_cmdCount == 4'd0) begin
                    w_nextState     = ST_IDLE;
                    w_nextRemaining = '0;
                    w_nextTimer     = '0;
                end else begin
                    w_nextState     = ST_ON;
                    w_nextRemaining = w_cmdCount;
                    w_nextTimer     = phaseLast(w_cmdOn);
                end
            end else begin
                case (r_state)
                    ST_ON: begin
                        if (r_timer == '0) begin
                            w_nextRemaining = r_remaining - 4'd1;
                            if (r_remaining == 4'd1) begin
                                w_nextState = ST_IDLE;
                            end else begin
                                w_nextState = ST_OFF;
                                w_nextTimer = phaseLast(r_offUnits);
                            end
                        end else begin
                            w_nextTimer = r_timer - DW'(1);
                        end
                    end
                    ST_OFF: begin
                        if (r_timer == '0) begin
                            w_nextState = ST_ON;
                            w_nextTimer = phaseLast(r_onUnits);
                        end else begin
                            w_nextTimer = r_timer - DW'(1);
                        end
                    end
                    default: begin
                        w_nextState = ST_IDLE;
                    end
                endcase
            end
        end

        // Output decode from the current state, registered one cycle later.
        always_comb begin
            w_ledDrive  = (r_state == ST_ON);
            w_busyDrive = (r_state != ST_IDLE);
        end

        assign ledMotorOut[p] = r_led;
        assign mmioBoardInput[32*p +: 32] = {5'b0, r_busy, w_deb[9:8], w_deb[7:4], w_deb[3:0],
                                             r_analog[7:4], 4'b0, r_analog[3:0], 4'b0};
    end

endmodule
